// File: rtl/micro_sequencer_pkg.sv
// micro_seq_pkg: shared encodings for the micro-sequencer.
// Holds the state and sequencing-field encodings, the opcodes the dispatch
// tables recognise, and the control-store entry points they map to.
package micro_seq_pkg;

  localparam int UPC_W = 4;
  localparam int OP_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEQ_NEXT  = 3'b000,
    SEQ_DISP1 = 3'b001,
    SEQ_DISP2 = 3'b010,
    SEQ_FETCH = 3'b011,
    SEQ_BZ    = 3'b100,
    SEQ_CALL  = 3'b101,
    SEQ_RET   = 3'b110,
    SEQ_HALT  = 3'b111
  } seq_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  // First-level dispatch targets (instruction class entry points)
  localparam logic [UPC_W-1:0] D1_RTYPE = 4'd6;
  localparam logic [UPC_W-1:0] D1_MEM   = 4'd2;
  localparam logic [UPC_W-1:0] D1_BEQ   = 4'd8;
  localparam logic [UPC_W-1:0] D1_J     = 4'd9;
  localparam logic [UPC_W-1:0] D1_ADDI  = 4'd10;

  // Second-level dispatch targets (load vs store split)
  localparam logic [UPC_W-1:0] D2_LW    = 4'd3;
  localparam logic [UPC_W-1:0] D2_SW    = 4'd5;

endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: control-word fields and status between the control
// store / datapath (master) and the micro-sequencer (slave).
interface micro_sequencer_if;
  import micro_seq_pkg::*;

  logic [OP_W-1:0]  op;
  logic [2:0]       seq;
  logic [UPC_W-1:0] utarget;
  logic             mem_req;
  logic             mem_ready;
  logic             zero;
  logic [UPC_W-1:0] upc;
  logic             ctrl_valid;
  logic             instr_done;
  logic             illegal_op;
  logic [1:0]       state;
  logic             bus_err;

  modport master (
    output op, seq, utarget, mem_req, mem_ready, zero,
    input  upc, ctrl_valid, instr_done, illegal_op, state, bus_err
  );

  modport slave (
    input  op, seq, utarget, mem_req, mem_ready, zero,
    output upc, ctrl_valid, instr_done, illegal_op, state, bus_err
  );

endinterface

// File: rtl/micro_sequencer_dispatch.sv
// micro_dispatch: combinational opcode decode into the two dispatch-table
// entry points, with a valid flag per table for undecodable opcodes.
module micro_dispatch
  import micro_seq_pkg::*;
(
  input  logic [OP_W-1:0]  i_op,
  output logic [UPC_W-1:0] o_disp1_addr,
  output logic [UPC_W-1:0] o_disp2_addr,
  output logic             o_disp1_ok,
  output logic             o_disp2_ok
);

  // First-level table: one entry per instruction class
  always_comb begin
    o_disp1_addr = '0;
    o_disp1_ok   = 1'b1;
    case (i_op)
      OP_RTYPE: o_disp1_addr = D1_RTYPE;
      OP_LW:    o_disp1_addr = D1_MEM;
      OP_SW:    o_disp1_addr = D1_MEM;
      OP_BEQ:   o_disp1_addr = D1_BEQ;
      OP_J:     o_disp1_addr = D1_J;
      OP_ADDI:  o_disp1_addr = D1_ADDI;
      default:  o_disp1_ok   = 1'b0;
    endcase
  end

  // Second-level table: only memory instructions branch here
  always_comb begin
    o_disp2_addr = '0;
    o_disp2_ok   = 1'b1;
    case (i_op)
      OP_LW:   o_disp2_addr = D2_LW;
      OP_SW:   o_disp2_addr = D2_SW;
      default: o_disp2_ok   = 1'b0;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: next-micro-address sequencer with opcode dispatch,
// conditional branch, one-level micro-subroutine, memory stall handshake and
// halt on illegal opcode / unmatched return.
// Optional feature: define MICRO_SEQ_TIMEOUT_EN to add a stall-cycle counter
// that raises a sticky bus_err and halts after STALL_MAX stalled cycles.
module micro_sequencer #(
  parameter int UPC_W     = micro_seq_pkg::UPC_W,
  parameter int OP_W      = micro_seq_pkg::OP_W,
  parameter int STALL_MAX = 15
) (
  input logic              clk,
  input logic              rst,
  micro_sequencer_if.slave bus
);
  import micro_seq_pkg::*;

  state_t           r_state;
  state_t           w_state_nxt;
  seq_t             w_seq;
  logic [UPC_W-1:0] r_upc;
  logic [UPC_W-1:0] w_upc_nxt;
  logic [UPC_W-1:0] w_upc_inc;
  logic [UPC_W-1:0] r_ret_reg;
  logic [UPC_W-1:0] w_ret_reg_nxt;
  logic             r_ret_valid;
  logic             w_ret_valid_nxt;
  logic             r_instr_done;
  logic             w_instr_done_nxt;
  logic             r_illegal;
  logic             w_illegal_nxt;
  logic             w_step;
  logic [UPC_W-1:0] w_disp1_addr;
  logic [UPC_W-1:0] w_disp2_addr;
  logic             w_disp1_ok;
  logic             w_disp2_ok;
  logic [OP_W-1:0]  w_op;

`ifdef MICRO_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(STALL_MAX + 1);
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] w_stall_cnt_inc;
  logic [CNT_W-1:0] w_stall_cnt_nxt;
  logic             r_bus_err;
  logic             w_bus_err_nxt;
`endif

  assign w_op      = bus.op;
  assign w_seq     = seq_t'(bus.seq);
  assign w_upc_inc = r_upc + UPC_W'(1);

  micro_dispatch u_dispatch (
    .i_op         (w_op),
    .o_disp1_addr (w_disp1_addr),
    .o_disp2_addr (w_disp2_addr),
    .o_disp1_ok   (w_disp1_ok),
    .o_disp2_ok   (w_disp2_ok)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and next micro-address; a stalled word is sequenced on the
  // same edge that memory becomes ready, so resume costs no extra cycle
  always_comb begin
    w_state_nxt      = r_state;
    w_upc_nxt        = r_upc;
    w_ret_reg_nxt    = r_ret_reg;
    w_ret_valid_nxt  = r_ret_valid;
    w_instr_done_nxt = 1'b0;
    w_illegal_nxt    = r_illegal;
    w_step           = 1'b0;
`ifdef MICRO_SEQ_TIMEOUT_EN
    w_stall_cnt_inc  = r_stall_cnt + CNT_W'(1);
    w_bus_err_nxt    = r_bus_err;
`endif

    case (r_state)
      ST_IDLE: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.mem_req && !bus.mem_ready) w_state_nxt = ST_STALL;
        else                               w_step      = 1'b1;
      end
      ST_STALL: begin
        if (bus.mem_ready) begin
          w_state_nxt = ST_RUN;
          w_step      = 1'b1;
        end
`ifdef MICRO_SEQ_TIMEOUT_EN
        else if (w_stall_cnt_inc == CNT_W'(STALL_MAX)) begin
          w_bus_err_nxt = 1'b1;
          w_state_nxt   = ST_HALT;
        end
`endif
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_HALT;
    endcase

    if (w_step) begin
      w_state_nxt = ST_RUN;
      case (w_seq)
        SEQ_NEXT: w_upc_nxt = w_upc_inc;
        SEQ_DISP1: begin
          if (w_disp1_ok) w_upc_nxt = w_disp1_addr;
          else begin
            w_illegal_nxt = 1'b1;
            w_state_nxt   = ST_HALT;
          end
        end
        SEQ_DISP2: begin
          if (w_disp2_ok) w_upc_nxt = w_disp2_addr;
          else begin
            w_illegal_nxt = 1'b1;
            w_state_nxt   = ST_HALT;
          end
        end
        SEQ_FETCH: begin
          w_upc_nxt        = '0;
          w_instr_done_nxt = 1'b1;
        end
        SEQ_BZ: w_upc_nxt = bus.zero ? bus.utarget : w_upc_inc;
        SEQ_CALL: begin
          w_ret_reg_nxt   = w_upc_inc;
          w_ret_valid_nxt = 1'b1;
          w_upc_nxt       = bus.utarget;
        end
        SEQ_RET: begin
          if (r_ret_valid) begin
            w_upc_nxt       = r_ret_reg;
            w_ret_valid_nxt = 1'b0;
          end else begin
            w_illegal_nxt = 1'b1;
            w_state_nxt   = ST_HALT;
          end
        end
        SEQ_HALT: w_state_nxt = ST_HALT;
        default:  w_state_nxt = ST_HALT;
      endcase
    end

`ifdef MICRO_SEQ_TIMEOUT_EN
    // Counter only runs while remaining in STALL; any exit clears it
    w_stall_cnt_nxt = (r_state == ST_STALL && w_state_nxt == ST_STALL) ?
                      w_stall_cnt_inc : '0;
`endif
  end

  // Micro-address, return register and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upc        <= '0;
      r_ret_reg    <= '0;
      r_ret_valid  <= 1'b0;
      r_instr_done <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_upc        <= w_upc_nxt;
      r_ret_reg    <= w_ret_reg_nxt;
      r_ret_valid  <= w_ret_valid_nxt;
      r_instr_done <= w_instr_done_nxt;
      r_illegal    <= w_illegal_nxt;
    end
  end

`ifdef MICRO_SEQ_TIMEOUT_EN
  // Stall-cycle counter and sticky bus error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end
  assign bus.bus_err = r_bus_err;
`else
  assign bus.bus_err = 1'b0;
`endif

  // Outputs: the control word is only effective while running
  always_comb begin
    bus.ctrl_valid = (r_state == ST_RUN);
    bus.upc        = r_upc;
    bus.instr_done = r_instr_done;
    bus.illegal_op = r_illegal;
    bus.state      = r_state;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Next-micro-address sequencer for the multi-cycle microprogrammed CPU.
- Replaces the flat next-address mux with a sequencer that supports:
  - dispatch on opcode;
  - conditional micro-branch;
  - a one-level micro-subroutine;
  - memory-ready stall handshake;
  - halt on illegal opcode.
- Sits between the control-store ROM, which it drives via upc, and the datapath, which it gates via ctrl_valid.

Parameters:
- UPC_W, 4, micro-address width (16-entry control store)
- OP_W, 6, opcode width
- STALL_MAX, 15, stall-cycle limit before bus error (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- op  in  6  opcode from instruction register
- seq  in  3  sequencing field of current control word
- utarget  in  4  branch/call target field of current control word
- mem_req  in  1  current control word performs a memory access
- mem_ready  in  1  memory completes the access this cycle
- zero  in  1  ALU zero flag
- upc  out  4  current micro-address to control store
- ctrl_valid  out  1  control word is effective this cycle (gates register writes)
- instr_done  out  1  one-cycle pulse when a FETCH return is taken
- illegal_op  out  1  sticky; set on undecodable dispatch or unmatched RET
- state  out  2  IDLE=0, RUN=1, STALL=2, HALT=3
- bus_err  out  1  sticky stall timeout (tied 0 without the optional feature)

Behaviour:
- Reset (asynchronous, any state, including mid-stall):
  - upc=0, state=IDLE, ctrl_valid=0, instr_done=0, illegal_op=0, bus_err=0;
  - ret_reg=0, ret_valid=0, stall_cnt=0.
- IDLE: one cycle; upc stays 0, ctrl_valid=0; next state RUN.
- RUN: ctrl_valid=1. If mem_req=1 and mem_ready=0, go to STALL with upc held. Otherwise upc updates next edge per seq:
  - 000 NEXT: upc+1, modulo 16 (15 wraps to 0).
  - 001 DISP1: upc = DISP1[op]. R-type(000000)->6, lw(100011)->2, sw(101011)->2, beq(000100)->8, j(000010)->9, addi(001000)->10.
  - 010 DISP2: upc = DISP2[op]. lw->3, sw->5.
  - 011 FETCH: upc=0; instr_done=1 for that edge's following cycle.
  - 100 BZ: upc = zero ? utarget : upc+1.
  - 101 CALL: ret_reg=upc+1, ret_valid=1, upc=utarget. A CALL while ret_valid=1 overwrites the saved entry (single level).
  - 110 RET: if ret_valid, upc=ret_reg and ret_valid=0; else illegal_op=1 and go to HALT.
  - 111 HALT: go to HALT, upc held.
- Any op not listed in the dispatch table used: illegal_op=1, state HALT, upc held.
- STALL:
  - ctrl_valid=0; upc and ret state frozen.
  - When mem_ready=1: return to RUN, and the sequencing of the held word is applied on that same edge (single-cycle resume latency).
  - mem_ready=1 in the same cycle as mem_req in RUN means no stall.
- HALT: ctrl_valid=0, upc frozen; exit only via rst.
- Latency: combinational decode, registered upc; one edge per micro-step.

Optional Feature:
- Macro: MICRO_SEQ_TIMEOUT_EN.
- With it:
  - stall_cnt increments each STALL cycle and clears on leaving STALL;
  - when it reaches STALL_MAX with mem_ready still 0, bus_err=1 (sticky) and state goes to HALT.
- Without it: STALL waits indefinitely; bus_err is constant 0 and no counter is synthesised.

Decomposition:
- Package micro_seq_pkg:
  - state encodings;
  - seq encodings (SEQ_NEXT..SEQ_HALT);
  - opcode constants;
  - DISP1/DISP2 target constants;
  - UPC_W.
- Sub-module micro_dispatch: combinational op -> {disp1_addr, disp2_addr, disp1_ok, disp2_ok}. The sequencer FSM and registers live in the top module.

Test Plan:
- rst pulsed mid-STALL at upc=3 -> upc=0 and state=IDLE immediately (asynchronous); state=RUN after one clock; sticky flags cleared.
- lw walk: op=100011 with seq NEXT at 0, DISP1 at 1, DISP2 at 2, FETCH at 3 -> upc sequence 0,1,2,3,0; instr_done high exactly one cycle.
- mem_req=1 with mem_ready low for 4 cycles at upc=3 -> state=STALL, ctrl_valid=0, upc held at 3 for 4 cycles; resumes to 4 on the edge where mem_ready=1.
- BZ at upc=8 with utarget=12: zero=1 -> upc=12; zero=0 -> upc=9. NEXT at upc=15 -> upc=0.
- CALL at upc=5 with utarget=13, then RET -> upc=13, then upc=6. A second RET -> illegal_op=1, state=HALT.
- op=111111 at DISP1 -> illegal_op=1, state=HALT, upc frozen. With MICRO_SEQ_TIMEOUT_EN, 15 stall cycles -> bus_err=1 and HALT.
